// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle of the multicycle MIPS: decoded instruction fields and
// memory/ALU status come in, per-cycle selects, enables and the 4-bit ALU operation go out.
// Combinational only; no storage, no flow control of its own.
// Ports (master = controller): in opcode, funct, zero, mem_ready; out pc_write, i_or_d,
//   mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
//   pc_source, ALUOperation, illegal_op, state.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] ALUOperation;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, ALUOperation, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, ALUOperation, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: decodes the latched instruction and drives datapath selects,
// enables and the ALU operation each cycle. Branch/jump 3 cycles, R/I/sw 4, lw 5 (mem_ready=1).
// Backpressure: FETCH, MEM_RD and MEM_WR hold with their request asserted until mem_ready.
// Ports: clk, reset (async, active-low), bus (master modport of mips_multicycle_control_if).
// Parameter ILLEGAL_TRAP: 0 = unsupported instruction returns to FETCH, 1 = park in HALT.
module mips_multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_control_if.master     bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EXEC   = 4'd3,
    S_R_WB     = 4'd4,
    S_I_EXEC   = 4'd5,
    S_I_WB     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_LUI = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b0111;

  // ALU A-input select
  localparam logic [1:0] A_PC = 2'd0;
  localparam logic [1:0] A_RS = 2'd1;
  localparam logic [1:0] A_RT = 2'd2;

  // ALU B-input select
  localparam logic [2:0] B_REG   = 3'd0;
  localparam logic [2:0] B_FOUR  = 3'd1;
  localparam logic [2:0] B_SEXT  = 3'd2;
  localparam logic [2:0] B_SEXT2 = 3'd3;
  localparam logic [2:0] B_ZEXT  = 3'd4;
  localparam logic [2:0] B_SHAMT = 3'd5;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  state_e state_q, state_d;

  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_op;
  logic       illegal_op;

  // Supported R-type functions; anything else is rejected in DECODE so R_EXEC
  // never sees an unknown funct while the IR is held.
  function automatic logic r_funct_legal(input logic [5:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR: r_funct_legal = 1'b1;
      default:                                              r_funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu_op(input logic [5:0] f);
    case (f)
      FN_SLL:  r_alu_op = ALU_SLL;
      FN_SRL:  r_alu_op = ALU_SRL;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_NOR:  r_alu_op = ALU_NOR;
      default: r_alu_op = ALU_ADD;
    endcase
  endfunction

  // Dispatch target out of DECODE; legal_dec low marks an unsupported instruction.
  state_e dispatch;
  logic   legal_dec;

  always_comb begin
    dispatch  = S_FETCH;
    legal_dec = 1'b1;
    case (bus.opcode)
      OP_RTYPE: begin
        dispatch  = S_R_EXEC;
        legal_dec = r_funct_legal(bus.funct);
      end
      OP_LW, OP_SW:                      dispatch = S_MEM_ADDR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  dispatch = S_I_EXEC;
      OP_BEQ, OP_BNE:                    dispatch = S_BRANCH;
      OP_J:                              dispatch = S_JUMP;
      default:                           legal_dec = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = A_PC;
    alu_src_b  = B_REG;
    pc_source  = PC_ALU;
    alu_op     = ALU_AND;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 is computed every FETCH cycle, but the IR and PC only commit
      // on the cycle the memory reports completion.
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = A_PC;
        alu_src_b = B_FOUR;
        alu_op    = ALU_ADD;
        pc_source = PC_ALU;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end

      // Branch target precomputed into ALUOut while the opcode is examined.
      S_DECODE: begin
        alu_src_a = A_PC;
        alu_src_b = B_SEXT2;
        alu_op    = ALU_ADD;
        if (legal_dec) begin
          state_d = dispatch;
        end else begin
          illegal_op = 1'b1;
          state_d    = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        end
      end

      S_R_EXEC: begin
        alu_op = r_alu_op(bus.funct);
        if (bus.funct == FN_SLL || bus.funct == FN_SRL) begin
          alu_src_a = A_RT;
          alu_src_b = B_SHAMT;
        end else begin
          alu_src_a = A_RS;
          alu_src_b = B_REG;
        end
        state_d = S_R_WB;
      end

      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      // Logical immediates are zero-extended; only addi sign-extends.
      S_I_EXEC: begin
        alu_src_a = A_RS;
        case (bus.opcode)
          OP_ADDI: begin alu_op = ALU_ADD; alu_src_b = B_SEXT; end
          OP_ANDI: begin alu_op = ALU_AND; alu_src_b = B_ZEXT; end
          OP_ORI:  begin alu_op = ALU_OR;  alu_src_b = B_ZEXT; end
          default: begin alu_op = ALU_LUI; alu_src_b = B_ZEXT; end
        endcase
        state_d = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = A_RS;
        alu_src_b = B_SEXT;
        alu_op    = ALU_ADD;
        state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      // ALU compares rs-rt; Zero resolves the branch in this same cycle.
      S_BRANCH: begin
        alu_src_a = A_RS;
        alu_src_b = B_REG;
        alu_op    = ALU_SUB;
        pc_source = PC_ALUOUT;
        pc_write  = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_source = PC_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      // Encodings 14/15 are unreachable; recover through IDLE.
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pc_write     = pc_write;
  assign bus.i_or_d       = i_or_d;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.ir_write     = ir_write;
  assign bus.reg_dst      = reg_dst;
  assign bus.mem_to_reg   = mem_to_reg;
  assign bus.reg_write    = reg_write;
  assign bus.alu_src_a    = alu_src_a;
  assign bus.alu_src_b    = alu_src_b;
  assign bus.pc_source    = pc_source;
  assign bus.ALUOperation = alu_op;
  assign bus.illegal_op   = illegal_op;
  assign bus.state        = state_q;

endmodule
